// File: rtl/prim_reqack_rx_fifo.sv
// Toggle REQ/ACK receive endpoint with a Depth-entry FIFO.
// ACK is withheld while the FIFO is full.
module prim_reqack_rx_fifo #(
  parameter int unsigned Width      = 8,
  parameter int unsigned Depth      = 2,
  parameter int unsigned SyncStages = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_tgl_i,
  input  logic [Width-1:0]           data_i,
  output logic                       ack_tgl_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       pending_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  seen_q, seen_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [Width-1:0]      mem_q [Depth];
  logic [Width-1:0]      mem_d [Depth];

  logic req_s;
  logic pending;
  logic pop;
  logic accept;

  assign req_s   = sync_q[SyncStages-1];
  assign pending = req_s != seen_q;
  assign valid_o = count_q != '0;
  assign pop     = valid_o && ready_i;
  // A pop in the same cycle frees a slot for the incoming request.
  assign accept  = pending && ((count_q < DepthC) || pop);

  always_comb begin
    sync_d   = {sync_q[SyncStages-2:0], req_tgl_i};
    seen_d   = seen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (accept) begin
      seen_d   = ~seen_q;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      for (int i = 0; i < Depth; i++) begin
        if (wr_ptr_q == PtrW'(i)) mem_d[i] = data_i;
      end
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    unique case (1'b1)
      accept && !pop: count_d = count_q + CntW'(1);
      pop && !accept: count_d = count_q - CntW'(1);
      default:        count_d = count_q;
    endcase
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (rd_ptr_q == PtrW'(i)) data_o = mem_q[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      seen_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      sync_q   <= sync_d;
      seen_q   <= seen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign ack_tgl_o = seen_q;
  assign count_o   = count_q;
  assign pending_o = pending && !accept;

  if (Width == 0) begin : gen_assert_init_width
    $error("Width must be at least 1");
  end
  if (Depth == 0) begin : gen_assert_init_depth
    $error("Depth must be at least 1");
  end
  if (SyncStages < 2) begin : gen_assert_init_sync
    $error("SyncStages must be at least 2");
  end

  a_count_le_depth: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    count_q <= DepthC);

  a_pop_needs_valid: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    pop |-> valid_o);

  // Sender must hold data_i for the whole pending window.
  a_data_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (pending && $past(pending)) |-> $stable(data_i));

endmodule

// File: tb/tb_prim_reqack_rx_fifo.sv
// Bench for prim_reqack_rx_fifo: Depth 2, 3 and 1 instances.
// Sender and consumer are driven per instance index.
module tb_prim_reqack_rx_fifo;

  int n_checks = 0;
  int n_fail   = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      req, rdy, ack, vld, pend;
  logic [2:0][7:0] din, dout;
  logic [1:0]      cnt0, cnt1;
  logic            cnt2;

  prim_reqack_rx_fifo #(.Width(8), .Depth(2), .SyncStages(2)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_tgl_i(req[0]), .data_i(din[0]),
    .ack_tgl_o(ack[0]), .valid_o(vld[0]),
    .ready_i(rdy[0]), .data_o(dout[0]),
    .count_o(cnt0), .pending_o(pend[0]));

  prim_reqack_rx_fifo #(.Width(8), .Depth(3), .SyncStages(2)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_tgl_i(req[1]), .data_i(din[1]),
    .ack_tgl_o(ack[1]), .valid_o(vld[1]),
    .ready_i(rdy[1]), .data_o(dout[1]),
    .count_o(cnt1), .pending_o(pend[1]));

  prim_reqack_rx_fifo #(.Width(8), .Depth(1), .SyncStages(2)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_tgl_i(req[2]), .data_i(din[2]),
    .ack_tgl_o(ack[2]), .valid_o(vld[2]),
    .ready_i(rdy[2]), .data_o(dout[2]),
    .count_o(cnt2), .pending_o(pend[2]));

  function automatic int get_cnt(input int k);
    if (k == 0) return int'(cnt0);
    if (k == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  function automatic int depth_of(input int k);
    if (k == 0) return 2;
    if (k == 1) return 3;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    din[k] = d;
    req[k] = ~req[k];
  endtask

  task automatic wait_ack(input int k);
    for (int i = 0; i < 20 && ack[k] !== req[k]; i++) tick();
    n_checks++;
    if (ack[k] !== req[k]) begin
      n_fail++;
      $display("FAIL wait_ack[%0d]: ack=%b req=%b", k, ack[k], req[k]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; rdy = '0; din = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({ack[k], vld[k], pend[k], dout[k]} !== 11'd0 || get_cnt(k) != 0) begin
        n_fail++;
        $display("FAIL reset[%0d]: ack=%b vld=%b pend=%b dout=%h cnt=%0d want all 0",
                 k, ack[k], vld[k], pend[k], dout[k], get_cnt(k));
      end
    end
  endtask

  task automatic test_single();
    rdy[0] = 1'b0;
    send(0, 8'hA5);
    tick();
    tick();
    n_checks++;
    if ({ack[0], vld[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_early: ack=%b vld=%b want 0 0", ack[0], vld[0]);
    end
    tick();
    n_checks++;
    if ({ack[0], vld[0], dout[0]} !== {2'b11, 8'hA5} || cnt0 !== 2'd1) begin
      n_fail++;
      $display("FAIL single_e3: ack=%b vld=%b dout=%h cnt=%0d want 1 1 a5 1",
               ack[0], vld[0], dout[0], cnt0);
    end
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    n_checks++;
    if (vld[0] !== 1'b0 || cnt0 !== 2'd0) begin
      n_fail++;
      $display("FAIL single_drain: vld=%b cnt=%0d want 0 0", vld[0], cnt0);
    end
  endtask

  task automatic test_fill();
    logic a;
    rdy[0] = 1'b0;
    send(0, 8'h11); wait_ack(0);
    send(0, 8'h22); wait_ack(0);
    a = ack[0];
    send(0, 8'h33);
    tick(); tick();
    n_checks++;
    if (cnt0 !== 2'd2 || pend[0] !== 1'b1 || ack[0] !== a) begin
      n_fail++;
      $display("FAIL fill_full: cnt=%0d pend=%b ack=%b want 2 1 %b", cnt0, pend[0], ack[0], a);
    end
    tick(); tick(); tick();
    n_checks++;
    if (pend[0] !== 1'b1 || ack[0] !== a || dout[0] !== 8'h11) begin
      n_fail++;
      $display("FAIL fill_hold: pend=%b ack=%b dout=%h want 1 %b 11", pend[0], ack[0], dout[0], a);
    end
    rdy[0] = 1'b1;
    tick();
    rdy[0] = 1'b0;
    n_checks++;
    if (ack[0] !== ~a || cnt0 !== 2'd2 || dout[0] !== 8'h22 || pend[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_pop: ack=%b cnt=%0d dout=%h pend=%b want %b 2 22 0",
               ack[0], cnt0, dout[0], pend[0], ~a);
    end
    rdy[0] = 1'b1;
    tick();
    n_checks++;
    if (cnt0 !== 2'd1 || dout[0] !== 8'h33) begin
      n_fail++;
      $display("FAIL fill_next: cnt=%0d dout=%h want 1 33", cnt0, dout[0]);
    end
    tick();
    rdy[0] = 1'b0;
    n_checks++;
    if (cnt0 !== 2'd0 || vld[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_empty: cnt=%0d vld=%b want 0 0", cnt0, vld[0]);
    end
  endtask

  task automatic run_stream(input int k, input int n, input bit rnd, input string nm);
    logic [7:0] model_q [$];
    logic [7:0] d;
    int sent  = 0;
    int got   = 0;
    int guard = 0;
    while ((sent < n || got < n) && guard < 3000) begin
      rdy[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld[k] && rdy[k]) begin
        n_checks++;
        if (model_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_extra: popped %h with nothing outstanding", nm, dout[k]);
        end else begin
          d = model_q.pop_front();
          if (dout[k] !== d) begin
            n_fail++;
            $display("FAIL %s_order: popped %h want %h", nm, dout[k], d);
          end
        end
        got++;
      end
      if (sent < n && ack[k] === req[k]) begin
        d = rnd ? 8'($urandom) : 8'(sent);
        send(k, d);
        model_q.push_back(d);
        sent++;
      end
      n_checks++;
      if (get_cnt(k) > depth_of(k)) begin
        n_fail++;
        $display("FAIL %s_bound: cnt=%0d want <= %0d", nm, get_cnt(k), depth_of(k));
      end
      tick();
      guard++;
    end
    rdy[k] = 1'b0;
    n_checks++;
    if (guard >= 3000 || model_q.size() != 0 || get_cnt(k) != 0) begin
      n_fail++;
      $display("FAIL %s_done: left=%0d cnt=%0d guard=%0d want 0 0 <3000",
               nm, model_q.size(), get_cnt(k), guard);
    end
  endtask

  task automatic test_depth1();
    logic a;
    rdy[2] = 1'b0;
    send(2, 8'h5A); wait_ack(2);
    a = ack[2];
    send(2, 8'hC3);
    tick(); tick(); tick();
    n_checks++;
    if ({pend[2], vld[2], dout[2], cnt2} !== {2'b11, 8'h5A, 1'b1} || ack[2] !== a) begin
      n_fail++;
      $display("FAIL d1_hold: pend=%b vld=%b dout=%h cnt=%0d ack=%b want 1 1 5a 1 %b",
               pend[2], vld[2], dout[2], cnt2, ack[2], a);
    end
    rdy[2] = 1'b1;
    tick();
    rdy[2] = 1'b0;
    n_checks++;
    if ({vld[2], dout[2], cnt2, pend[2]} !== {1'b1, 8'hC3, 1'b1, 1'b0} || ack[2] !== ~a) begin
      n_fail++;
      $display("FAIL d1_swap: vld=%b dout=%h cnt=%0d pend=%b ack=%b want 1 c3 1 0 %b",
               vld[2], dout[2], cnt2, pend[2], ack[2], ~a);
    end
    rdy[2] = 1'b1;
    tick();
    rdy[2] = 1'b0;
    n_checks++;
    if (vld[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL d1_drain: vld=%b want 0", vld[2]);
    end
  endtask

  task automatic test_reset_mid();
    rdy[0] = 1'b0;
    send(0, 8'h01); wait_ack(0);
    send(0, 8'h02); wait_ack(0);
    send(0, 8'h03);
    tick(); tick();
    n_checks++;
    if (cnt0 !== 2'd2 || pend[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_setup: cnt=%0d pend=%b want 2 1", cnt0, pend[0]);
    end
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    n_checks++;
    if ({ack[0], vld[0], pend[0], dout[0], cnt0} !== 13'd0) begin
      n_fail++;
      $display("FAIL rmid_clear: ack=%b vld=%b pend=%b dout=%h cnt=%0d want all 0",
               ack[0], vld[0], pend[0], dout[0], cnt0);
    end
    tick();
  endtask

  task automatic test_reset_release_req();
    rst_n = 1'b0;
    req = '0;
    req[0] = 1'b1;
    din[0] = 8'h77;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if ({ack[0], vld[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL rrel_early: ack=%b vld=%b want 0 0", ack[0], vld[0]);
    end
    tick();
    n_checks++;
    if ({ack[0], vld[0], dout[0]} !== {2'b11, 8'h77} || cnt0 !== 2'd1) begin
      n_fail++;
      $display("FAIL rrel_xfer: ack=%b vld=%b dout=%h cnt=%0d want 1 1 77 1",
               ack[0], vld[0], dout[0], cnt0);
    end
    tick(); tick(); tick();
    n_checks++;
    if (cnt0 !== 2'd1 || ack[0] !== 1'b1 || pend[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rrel_once: cnt=%0d ack=%b pend=%b want 1 1 0", cnt0, ack[0], pend[0]);
    end
  endtask

  initial begin
    req = '0; rdy = '0; din = '0;
    do_reset();
    test_reset();
    test_single();
    test_fill();
    run_stream(1, 10, 1'b0, "order");
    test_depth1();
    run_stream(1, 40, 1'b1, "rand_d3");
    run_stream(0, 30, 1'b1, "rand_d2");
    run_stream(2, 20, 1'b1, "rand_d1");
    test_reset_mid();
    test_reset_release_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
